// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR filter: one signed MAC swept over NTAPS taps per sample,
// with a circular sample buffer, a runtime-writable coefficient file and valid/ready on both sides.
module fir_mac_sequencer #(
    parameter int unsigned NTAPS = 15,
    parameter int unsigned DW    = 16,
    parameter int unsigned CW    = 16,
    parameter int unsigned ACCW  = 36,
    parameter int unsigned SHIFT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_sat,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [CW-1:0] cfg_data,
    output logic          cfg_err,
    output logic          busy
);
    localparam int unsigned IW  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int unsigned IW1 = IW + 1;
    localparam int unsigned PRW = DW + CW;
    localparam logic signed [ACCW-1:0] HALF = ACCW'(1) << (SHIFT - 1);
    localparam logic signed [ACCW-1:0] OMAX = ACCW'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACCW-1:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {IDLE, MAC, ROUND, HOLD} state_t;

    state_t                 state, state_nxt;
    logic [IW-1:0]          wptr, tap, rd_idx;
    logic signed [ACCW-1:0] acc, prod_ext, r;
    logic signed [PRW-1:0]  prod;
    logic [DW-1:0]          sample_mem [NTAPS];
    logic [CW-1:0]          coef       [NTAPS];
    logic [DW-1:0]          rnd_data;
    logic                   rnd_sat, accept, out_hs, last_tap, cfg_ok;

    // Default low-pass taps for the 15-tap build; other tap counts start from zero.
    function automatic logic [CW-1:0] coef_default(input int unsigned k);
        logic [CW-1:0] v;
        v = '0;
        if (NTAPS == 15) begin
            case (k)
                0, 14:   v = CW'(338);
                1, 13:   v = CW'(533);
                2, 12:   v = CW'(1080);
                3, 11:   v = CW'(1872);
                4, 10:   v = CW'(2754);
                5, 9:    v = CW'(3550);
                6, 8:    v = CW'(4102);
                7:       v = CW'(4300);
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    // Next-state and control strobes
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        out_hs    = 1'b0;
        last_tap  = (tap == IW'(NTAPS - 1));
        cfg_ok    = cfg_we && (state == IDLE) && ({1'b0, cfg_addr} < 5'(NTAPS));
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept    = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC:   if (last_tap) state_nxt = ROUND;
            ROUND: state_nxt = HOLD;
            HOLD: begin
                if (out_valid && out_ready) begin
                    out_hs    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Tap datapath: circular read index, full-precision product, rounding and saturation
    always_comb begin
        rd_idx   = (wptr >= tap) ? (wptr - tap) : IW'(IW1'(wptr) + IW1'(NTAPS) - IW1'(tap));
        prod     = $signed(coef[tap]) * $signed(sample_mem[rd_idx]);
        prod_ext = {{(ACCW - PRW){prod[PRW-1]}}, prod};
        r        = (acc + HALF) >>> SHIFT;
        rnd_data = r[DW-1:0];
        rnd_sat  = 1'b0;
        if (r > OMAX) begin
            rnd_data = OMAX[DW-1:0];
            rnd_sat  = 1'b1;
        end else if (r < OMIN) begin
            rnd_data = OMIN[DW-1:0];
            rnd_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == IDLE);
            busy     <= (state_nxt != IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            tap       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (accept) begin
                acc <= '0;
                tap <= '0;
            end else if (state == MAC) begin
                acc <= acc + prod_ext;
                tap <= tap + IW'(1);
            end
            if (state == ROUND) begin
                out_valid <= 1'b1;
                out_data  <= rnd_data;
                out_sat   <= rnd_sat;
                wptr      <= (wptr == IW'(NTAPS - 1)) ? '0 : wptr + IW'(1);
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Sample buffer and coefficient file; a write in the accept cycle is seen by that sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NTAPS; k++) begin
                sample_mem[k] <= '0;
                coef[k]       <= coef_default(k);
            end
        end else begin
            if (accept) sample_mem[wptr] <= in_data;
            if (cfg_ok) coef[cfg_addr[IW-1:0]] <= cfg_data;
        end
    end

endmodule
